// File: rtl/problem5b_pkg.sv
// Shared definitions for the problem5b Gray/binary converter.
// Default width plus reference conversion helpers (used by the bench scoreboard).
package problem5b_pkg;

  localparam int unsigned NUM_DEFAULT = 6;

  // Gray -> binary over the low n bits: b[i] is the XOR of g[n-1:i].
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int n);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < n) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  // Binary -> Gray over the low n bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] g, input int n);
    logic [31:0] mask;
    logic [31:0] gm;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    gm   = g & mask;
    return gm ^ (gm >> 1);
  endfunction

endpackage

// File: rtl/problem5b_gray2bin_comb.sv
// Combinational Gray -> binary XOR prefix chain, MSB first.
module gray2bin_comb #(
  parameter int unsigned NUM = 6
) (
  input  logic [NUM-1:0] g_i,
  output logic [NUM-1:0] b_o
);

  // Running XOR from the MSB down; each bit takes the prefix ending at its position.
  always_comb begin
    logic acc;
    b_o = '0;
    acc = 1'b0;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      acc    = acc ^ g_i[i];
      b_o[i] = acc;
    end
  end

endmodule

// File: rtl/problem5b.sv
// Registered Gray -> binary converter, one cycle latency, one word per cycle.
// Optional macro PROBLEM5B_BIN2GRAY_EN adds a 'mode' input selecting binary -> Gray.
module problem5b
  import problem5b_pkg::*;
#(
  parameter int unsigned NUM = NUM_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [NUM-1:0] g_in,
`ifdef PROBLEM5B_BIN2GRAY_EN
  input  logic           mode,
`endif
  output logic           out_valid,
  output logic [NUM-1:0] b_out
);

  logic [NUM-1:0] g2b;
  logic [NUM-1:0] conv;
  logic           out_valid_d, out_valid_q;
  logic [NUM-1:0] b_out_d, b_out_q;

  gray2bin_comb #(
    .NUM(NUM)
  ) u_gray2bin_comb (
    .g_i(g_in),
    .b_o(g2b)
  );

  // Select the conversion direction for the word being captured.
  always_comb begin
    conv = g2b;
`ifdef PROBLEM5B_BIN2GRAY_EN
    if (mode) begin
      conv = g_in ^ (g_in >> 1);
    end
`endif
  end

  // Next state: valid follows input valid; data loads only on a valid word.
  always_comb begin
    out_valid_d = in_valid;
    b_out_d     = b_out_q;
    if (in_valid) begin
      b_out_d = conv;
    end
  end

  // Output registers; reset clears both and drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      b_out_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      b_out_q     <= b_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_problem5b.sv
// Self-checking bench for problem5b (NUM = 6), with optional PROBLEM5B_BIN2GRAY_EN coverage.
module tb_problem5b;
  import problem5b_pkg::*;

  localparam int unsigned NUM = NUM_DEFAULT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic [NUM-1:0] g_in = '0;
  logic           mode = 1'b0;
  logic           out_valid;
  logic [NUM-1:0] b_out;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Reference model state.
  logic           exp_valid = 1'b0;
  logic [NUM-1:0] exp_b = '0;

  problem5b #(
    .NUM(NUM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .g_in     (g_in),
`ifdef PROBLEM5B_BIN2GRAY_EN
    .mode     (mode),
`endif
    .out_valid(out_valid),
    .b_out    (b_out)
  );

  always #5 clk = ~clk;

  // Model conversion: bit i is the parity of everything from bit i upward.
  function automatic logic [NUM-1:0] m_g2b(input logic [NUM-1:0] g);
    logic [NUM-1:0] b;
    for (int i = 0; i < int'(NUM); i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [NUM-1:0] m_conv(input logic [NUM-1:0] g, input logic m);
`ifdef PROBLEM5B_BIN2GRAY_EN
    if (m) return g ^ (g >> 1);
`endif
    return m_g2b(g);
  endfunction

  // Model register: captures on a clock edge while out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_b     <= '0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid) exp_b <= m_conv(g_in, mode);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid_vs_model", 32'(out_valid), 32'(exp_valid));
      chk("b_out_vs_model", 32'(b_out), 32'(exp_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [NUM-1:0] g, input logic m);
    in_valid = v;
    g_in     = g;
    mode     = m;
  endtask

  logic           seen [64];
  int             distinct;
  logic [NUM-1:0] tmp;

  initial begin
    // Pin the model itself against hand-computed values and the package helper.
    chk("model_100000", 32'(m_g2b(6'b100000)), 32'b111111);
    chk("model_111111", 32'(m_g2b(6'b111111)), 32'b101010);
    chk("model_110000", 32'(m_g2b(6'b110000)), 32'b100000);
    chk("model_000011", 32'(m_g2b(6'b000011)), 32'b000010);
    for (int v = 0; v < 64; v++) begin
      if (gray2bin(32'(v), 6) !== 32'(m_g2b(6'(v)))) chk("pkg_gray2bin", gray2bin(32'(v), 6),
                                                        32'(m_g2b(6'(v))));
    end
    chk("pkg_bin2gray_5", bin2gray(32'd5, 6), 32'd7);

    // Reset, asserted between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_b_out", 32'(b_out), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    checking = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #0;
    rst_n = 1'b1;

    // Single word.
    drive(1'b1, 6'b000001, 1'b0);
    step();
    chk("lit_000001_b", 32'(b_out), 32'b000001);
    chk("lit_000001_v", 32'(out_valid), 32'd1);

    // Directed literals, back to back.
    drive(1'b1, 6'b100000, 1'b0);
    step();
    chk("lit_100000", 32'(b_out), 32'b111111);
    drive(1'b1, 6'b111111, 1'b0);
    step();
    chk("lit_111111", 32'(b_out), 32'b101010);
    drive(1'b1, 6'b110000, 1'b0);
    step();
    chk("lit_110000", 32'(b_out), 32'b100000);

    // Full sweep, every output distinct.
    for (int v = 0; v < 64; v++) seen[v] = 1'b0;
    distinct = 0;
    for (int v = 0; v < 64; v++) begin
      drive(1'b1, 6'(v), 1'b0);
      step();
      if (!seen[b_out]) distinct++;
      seen[b_out] = 1'b1;
    end
    chk("sweep_distinct", 32'(distinct), 32'd64);

    // Hold across a 3-cycle gap with X on the data input.
    drive(1'b1, 6'b000011, 1'b0);
    step();
    chk("gap_load", 32'(b_out), 32'b000010);
    in_valid = 1'b0;
    g_in     = 'x;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("gap_hold_b", 32'(b_out), 32'b000010);
      chk("gap_hold_v", 32'(out_valid), 32'd0);
    end

    // Mid-cycle reset discards an in-flight word.
    drive(1'b1, 6'b100000, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_b", 32'(b_out), 32'd0);
    chk("midreset_v", 32'(out_valid), 32'd0);
    step();
    chk("inreset_b", 32'(b_out), 32'd0);
    drive(1'b0, 6'b000000, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_reset_b", 32'(b_out), 32'd0);
    chk("post_reset_v", 32'(out_valid), 32'd0);
    drive(1'b1, 6'b111111, 1'b0);
    step();
    chk("first_capture", 32'(b_out), 32'b101010);

`ifdef PROBLEM5B_BIN2GRAY_EN
    drive(1'b1, 6'b000101, 1'b1);
    step();
    chk("b2g_000101", 32'(b_out), 32'b000111);
    for (int v = 0; v < 64; v++) begin
      drive(1'b1, 6'(v), 1'b1);
      step();
      tmp = b_out;
      drive(1'b1, tmp, 1'b0);
      step();
      chk("round_trip", 32'(b_out), 32'(v));
    end
`endif

    drive(1'b0, 6'b000000, 1'b0);
    step();
    step();
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
